// File: rtl/regfile_2r1w.sv
// ---------------------------------------------------------------------------
// regfile_2r1w
//   Parametrised register file with two read ports (A, B) and one write port.
//   Sits between instruction decode (register specifiers) and the ALU operand
//   paths. Storage is a flop array so it can be cleared on reset.
//
//   Options:
//     ZERO_REG : register 0 reads as 0 and ignores writes
//     BYPASS   : a same-cycle legal write is forwarded to a matching read
//     REG_OUT  : 0 = combinational read, 1 = one-cycle registered read + valid
//
//   Ports:
//     clk, rst_n           clock, asynchronous active-low reset
//     we, waddr, wdata     write port, sampled on rising clk
//     re_a/b               read request (REG_OUT=1 only)
//     raddr_a/b            read addresses
//     rdata_a/b            read data
//     rvalid_a/b           read data valid (tied 1 when REG_OUT=0)
// ---------------------------------------------------------------------------
module regfile_2r1w #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int AW       = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    parameter int REG_OUT  = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re_a,
    input  logic [AW-1:0]    raddr_a,
    output logic [WIDTH-1:0] rdata_a,
    output logic             rvalid_a,
    input  logic             re_b,
    input  logic [AW-1:0]    raddr_b,
    output logic [WIDTH-1:0] rdata_b,
    output logic             rvalid_b
);

    // One extra bit so DEPTH = 2**AW still fits.
    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             wr_ok;
    logic [WIDTH-1:0] rd_a_c;
    logic [WIDTH-1:0] rd_b_c;

    // A write is legal only in range and, with ZERO_REG, not to register 0.
    // Bypass reuses this so an illegal write is never forwarded.
    always_comb begin
        wr_ok = we && ({1'b0, waddr} < DEPTH_W)
                && !((ZERO_REG != 0) && (waddr == '0));
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
            if (wr_ok && (waddr == AW'(i))) begin
                mem_d[i] = wdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    // Read value for one address. Out-of-range addresses match no entry of
    // the select loop and fall through as 0; wr_ok is false for them, so the
    // bypass cannot override that.
    function automatic logic [WIDTH-1:0] rd_val(input logic [AW-1:0] a);
        logic [WIDTH-1:0] v;
        v = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (a == AW'(i)) begin
                v = mem_q[i];
            end
        end
        if ((ZERO_REG != 0) && (a == '0)) begin
            v = '0;
        end else if ((BYPASS != 0) && wr_ok && (waddr == a)) begin
            v = wdata;
        end
        return v;
    endfunction

    always_comb begin
        rd_a_c = rd_val(raddr_a);
        rd_b_c = rd_val(raddr_b);
    end

    generate
        if (REG_OUT != 0) begin : g_reg_out
            logic [WIDTH-1:0] rdata_a_q, rdata_a_d;
            logic [WIDTH-1:0] rdata_b_q, rdata_b_d;
            logic             rvalid_a_q, rvalid_b_q;

            // Data holds when no request; valid is just the request delayed.
            always_comb begin
                rdata_a_d = re_a ? rd_a_c : rdata_a_q;
                rdata_b_d = re_b ? rd_b_c : rdata_b_q;
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rdata_a_q  <= '0;
                    rdata_b_q  <= '0;
                    rvalid_a_q <= 1'b0;
                    rvalid_b_q <= 1'b0;
                end else begin
                    rdata_a_q  <= rdata_a_d;
                    rdata_b_q  <= rdata_b_d;
                    rvalid_a_q <= re_a;
                    rvalid_b_q <= re_b;
                end
            end

            assign rdata_a  = rdata_a_q;
            assign rdata_b  = rdata_b_q;
            assign rvalid_a = rvalid_a_q;
            assign rvalid_b = rvalid_b_q;
        end else begin : g_comb_out
            // Read requests have no meaning for a combinational read.
            logic unused_re;
            assign unused_re = re_a ^ re_b;

            assign rdata_a  = rd_a_c;
            assign rdata_b  = rd_b_c;
            assign rvalid_a = 1'b1;
            assign rvalid_b = 1'b1;
        end
    endgenerate

endmodule

// File: tb/tb_regfile_2r1w.sv
// ---------------------------------------------------------------------------
// tb_regfile_2r1w
//   Three instances share one stimulus stream:
//     u0 : DEPTH 32, ZERO_REG 1, BYPASS 1, REG_OUT 0
//     u1 : DEPTH 24, ZERO_REG 0, BYPASS 0, REG_OUT 0
//     u2 : DEPTH 32, ZERO_REG 1, BYPASS 1, REG_OUT 1
//   Expected values come from a behavioural model and are pushed onto a
//   scoreboard queue when stimulus is driven, then popped and compared when
//   the DUT output is due (same cycle for u0/u1, next cycle for u2).
// ---------------------------------------------------------------------------
module tb_regfile_2r1w;

    typedef struct {
        string       tag;
        int          inst;
        bit          port;   // 0 = A, 1 = B
        bit          isv;    // compare rvalid instead of rdata
        logic [31:0] exp;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        re_a, re_b;
    logic [4:0]  raddr_a, raddr_b;

    logic [31:0] rda [3];
    logic [31:0] rdb [3];
    logic        rva [3];
    logic        rvb [3];

    int          n_cmp = 0;
    int          n_err = 0;

    exp_t        qc [$];   // due at this cycle's sample point
    exp_t        qr [$];   // due one cycle after being pushed

    // model state
    int          DEP [3] = '{32, 24, 32};
    bit          ZR  [3] = '{1'b1, 1'b0, 1'b1};
    bit          BP  [3] = '{1'b1, 1'b0, 1'b1};
    logic [31:0] mdl [3][32];
    logic [31:0] hold_a, hold_b;

    regfile_2r1w #(.WIDTH(32), .DEPTH(32), .AW(5), .ZERO_REG(1), .BYPASS(1), .REG_OUT(0)) u0 (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
        .re_a(re_a), .raddr_a(raddr_a), .rdata_a(rda[0]), .rvalid_a(rva[0]),
        .re_b(re_b), .raddr_b(raddr_b), .rdata_b(rdb[0]), .rvalid_b(rvb[0]));

    regfile_2r1w #(.WIDTH(32), .DEPTH(24), .AW(5), .ZERO_REG(0), .BYPASS(0), .REG_OUT(0)) u1 (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
        .re_a(re_a), .raddr_a(raddr_a), .rdata_a(rda[1]), .rvalid_a(rva[1]),
        .re_b(re_b), .raddr_b(raddr_b), .rdata_b(rdb[1]), .rvalid_b(rvb[1]));

    regfile_2r1w #(.WIDTH(32), .DEPTH(32), .AW(5), .ZERO_REG(1), .BYPASS(1), .REG_OUT(1)) u2 (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
        .re_a(re_a), .raddr_a(raddr_a), .rdata_a(rda[2]), .rvalid_a(rva[2]),
        .re_b(re_b), .raddr_b(raddr_b), .rdata_b(rdb[2]), .rvalid_b(rvb[2]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic bit legal(int k);
        return we && (int'(waddr) < DEP[k]) && !(ZR[k] && waddr == 5'd0);
    endfunction

    function automatic logic [31:0] readval(int k, logic [4:0] a);
        if (int'(a) >= DEP[k]) return 32'h0;
        if (ZR[k] && a == 5'd0) return 32'h0;
        if (BP[k] && legal(k) && waddr == a) return wdata;
        return mdl[k][a];
    endfunction

    function automatic logic [31:0] actual(int k, bit port, bit isv);
        if (isv) return port ? {31'b0, rvb[k]} : {31'b0, rva[k]};
        return port ? rdb[k] : rda[k];
    endfunction

    function automatic exp_t mk(string tag, int k, bit port, bit isv, logic [31:0] v);
        exp_t e;
        e.tag = tag; e.inst = k; e.port = port; e.isv = isv; e.exp = v;
        return e;
    endfunction

    task automatic chk(exp_t e);
        logic [31:0] a;
        a = actual(e.inst, e.port, e.isv);
        n_cmp++;
        assert (a === e.exp) else begin
            n_err++;
            $error("FAIL %s u%0d %s%s: observed %h expected %h", e.tag, e.inst,
                   e.port ? "B" : "A", e.isv ? " rvalid" : " rdata", a, e.exp);
        end
    endtask

    task automatic drain();
        while (qc.size() > 0) chk(qc.pop_front());
        while (qr.size() > 0) chk(qr.pop_front());
    endtask

    // One clock cycle with the currently driven inputs. Entered and left
    // #1 after a rising edge.
    task automatic cycle(string tag);
        exp_t nxt [$];
        logic [31:0] v;
        for (int k = 0; k < 2; k++) begin
            qc.push_back(mk(tag, k, 1'b0, 1'b0, readval(k, raddr_a)));
            qc.push_back(mk(tag, k, 1'b1, 1'b0, readval(k, raddr_b)));
            qc.push_back(mk(tag, k, 1'b0, 1'b1, 32'd1));
            qc.push_back(mk(tag, k, 1'b1, 1'b1, 32'd1));
        end
        @(negedge clk);
        drain();
        // registered-read expectations for u2, due after the coming edge
        v = re_a ? readval(2, raddr_a) : hold_a;
        hold_a = v;
        nxt.push_back(mk(tag, 2, 1'b0, 1'b0, v));
        nxt.push_back(mk(tag, 2, 1'b0, 1'b1, {31'b0, re_a}));
        v = re_b ? readval(2, raddr_b) : hold_b;
        hold_b = v;
        nxt.push_back(mk(tag, 2, 1'b1, 1'b0, v));
        nxt.push_back(mk(tag, 2, 1'b1, 1'b1, {31'b0, re_b}));
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            if (legal(k)) mdl[k][waddr] = wdata;
        end
        qr = nxt;
        #1;
    endtask

    // Asynchronous reset asserted away from any clock edge; outputs are
    // checked while reset is still low, then reset is released.
    task automatic do_reset(string tag);
        we = 1'b0;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < 32; i++) mdl[k][i] = 32'h0;
        hold_a = 32'h0;
        hold_b = 32'h0;
        qc.delete();
        qr.delete();
        for (int k = 0; k < 2; k++) begin
            qc.push_back(mk(tag, k, 1'b0, 1'b0, 32'h0));
            qc.push_back(mk(tag, k, 1'b1, 1'b0, 32'h0));
        end
        qc.push_back(mk(tag, 2, 1'b0, 1'b0, 32'h0));
        qc.push_back(mk(tag, 2, 1'b1, 1'b0, 32'h0));
        qc.push_back(mk(tag, 2, 1'b0, 1'b1, 32'h0));
        qc.push_back(mk(tag, 2, 1'b1, 1'b1, 32'h0));
        drain();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b1; we = 1'b0; waddr = '0; wdata = '0;
        re_a = 1'b0; re_b = 1'b0; raddr_a = '0; raddr_b = '0;
        hold_a = '0; hold_b = '0;

        #2;
        raddr_a = 5'd5; raddr_b = 5'd31;
        do_reset("reset");

        // every address reads 0 after reset
        re_a = 1'b1; re_b = 1'b1;
        for (int i = 0; i < 32; i++) begin
            raddr_a = 5'(i); raddr_b = 5'(31 - i);
            cycle("rst_read");
        end

        // ordinary write, then a write to register 0
        we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF; raddr_a = 5'd5; raddr_b = 5'd0;
        cycle("wr5");
        waddr = 5'd0; wdata = 32'h12345678;
        cycle("wr0");
        we = 1'b0;
        cycle("rd5_rd0");

        // same-cycle write/read of one address
        we = 1'b1; waddr = 5'd7; wdata = 32'hA5A5A5A5; raddr_a = 5'd7; raddr_b = 5'd5;
        cycle("bypass");
        we = 1'b0;
        cycle("bypass_next");

        // out-of-range for DEPTH 24, in range for DEPTH 32
        we = 1'b1; waddr = 5'd27; wdata = 32'hFFFFFFFF; raddr_a = 5'd27; raddr_b = 5'd23;
        cycle("wr27");
        we = 1'b0;
        for (int i = 0; i < 24; i++) begin
            raddr_a = 5'(i); raddr_b = 5'(i + 8);
            cycle("after_wr27");
        end

        // registered read: request, then idle cycles hold data
        we = 1'b1; waddr = 5'd3; wdata = 32'h00000011; re_a = 1'b0; re_b = 1'b0;
        cycle("wr3");
        we = 1'b0; re_a = 1'b1; raddr_a = 5'd3; re_b = 1'b1; raddr_b = 5'd3;
        cycle("req3");
        re_a = 1'b0; re_b = 1'b0; raddr_a = 5'd5; raddr_b = 5'd7;
        cycle("idle1");
        cycle("idle2");

        // back-to-back requests
        re_a = 1'b1; re_b = 1'b1;
        for (int i = 0; i < 8; i++) begin
            raddr_a = 5'(i); raddr_b = 5'(7 - i);
            cycle("b2b");
        end

        // registered read capturing a same-cycle write; illegal write to r0
        we = 1'b1; waddr = 5'd9; wdata = 32'hCAFEF00D; raddr_a = 5'd9; raddr_b = 5'd0;
        cycle("rbypass");
        waddr = 5'd0; wdata = 32'h0BADF00D; raddr_a = 5'd0; raddr_b = 5'd9;
        cycle("wr_r0");
        we = 1'b0;
        cycle("rbypass_next");

        // reset in the middle of a cycle with reads outstanding
        #1;
        do_reset("mid_reset");
        re_a = 1'b1; re_b = 1'b1;
        for (int i = 0; i < 32; i++) begin
            raddr_a = 5'(i); raddr_b = 5'(31 - i);
            cycle("post_reset");
        end
        re_a = 1'b0; re_b = 1'b0;
        cycle("flush1");
        cycle("flush2");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
